yuv422_pair_packer: RTL

Streaming controller that turns a one-pixel-per-beat RGB888 stream into a one-pair-per-beat packed YUV 4:2:2 stream. It sits between the video input front-end and the frame writer. It collects consecutive pixels into pairs, drives the existing combinational `rgb_to_yuv422` pair converter, and registers the packed result behind a valid/ready output. It also enforces the line length: odd-length lines are padded, and short or long lines are flagged.

---
 rtl/yuv422_pair_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/yuv422_pair_packer.sv
// RGB888 one-pixel-per-beat stream to packed YUYV pairs, with line-length policing.
// rgb_to_yuv422 is the combinational pair converter; the packer registers its result.
module rgb_to_yuv422 (
    input  logic [23:0] pix_a,
    input  logic [23:0] pix_b,
    output logic [7:0]  y1,
    output logic [7:0]  y2,
    output logic [7:0]  u,
    output logic [7:0]  v
);
    logic [23:0] pix  [2];
    logic [7:0]  y_px [2];
    logic [7:0]  u_px [2];
    logic [7:0]  v_px [2];
    logic [8:0]  u_sum;
    logic [8:0]  v_sum;

    assign pix[0] = pix_a;
    assign pix[1] = pix_b;

    // BT.601 studio-range integer coefficients, +128 rounding offset before the >>8
    for (genvar gi = 0; gi < 2; gi++) begin : g_px
        logic signed [17:0] r, g, b, y_t, u_t, v_t;
        assign r   = {10'd0, pix[gi][23:16]};
        assign g   = {10'd0, pix[gi][15:8]};
        assign b   = {10'd0, pix[gi][7:0]};
        assign y_t = (18'sd66 * r + 18'sd129 * g + 18'sd25 * b + 18'sd128) >>> 8;
        assign u_t = (18'sd112 * b - 18'sd38 * r - 18'sd74 * g + 18'sd128) >>> 8;
        assign v_t = (18'sd112 * r - 18'sd94 * g - 18'sd18 * b + 18'sd128) >>> 8;
        assign y_px[gi] = 8'(y_t + 18'sd16);
        assign u_px[gi] = 8'(u_t + 18'sd128);
        assign v_px[gi] = 8'(v_t + 18'sd128);
    end

    assign u_sum = {1'b0, u_px[0]} + {1'b0, u_px[1]};
    assign v_sum = {1'b0, v_px[0]} + {1'b0, v_px[1]};
    assign y1    = y_px[0];
    assign y2    = y_px[1];
    assign u     = 8'(u_sum >> 1);
    assign v     = 8'(v_sum >> 1);
endmodule

module yuv422_pair_packer #(
    parameter int LINE_WIDTH = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        err_short,
    output logic        err_long,
    input  logic        err_clr,
    output logic [15:0] pair_cnt
);
    localparam logic [11:0] LAST_IDX = 12'(LINE_WIDTH - 1);

    typedef enum logic {ST_EVEN, ST_ODD} state_t;

    state_t      state_reg, state_next;
    logic [23:0] p1_reg;
    logic [11:0] pix_cnt_reg;
    logic        m_valid_reg, m_last_reg;
    logic [31:0] m_data_reg;
    logic        err_short_reg, err_long_reg;
    logic [15:0] pair_cnt_reg;

    logic        s_fire, eff_last, emit, set_short, set_long;
    logic [23:0] conv_a, conv_b;
    logic [7:0]  y1_c, y2_c, u_c, v_c;

    assign s_ready   = !m_valid_reg || m_ready;
    assign s_fire    = s_valid && s_ready;
    assign eff_last  = s_last || (pix_cnt_reg == LAST_IDX);
    assign set_short = s_fire && s_last && (pix_cnt_reg < LAST_IDX);
    assign set_long  = s_fire && !s_last && (pix_cnt_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        conv_a     = p1_reg;
        conv_b     = s_data;
        if (s_fire) begin
            case (state_reg)
                ST_EVEN: begin
                    if (eff_last) begin
                        // lone pixel at end of line is paired with itself
                        emit   = 1'b1;
                        conv_a = s_data;
                    end else begin
                        state_next = ST_ODD;
                    end
                end
                ST_ODD: begin
                    emit       = 1'b1;
                    state_next = ST_EVEN;
                end
                default: state_next = ST_EVEN;
            endcase
        end
    end

    rgb_to_yuv422 u_conv (
        .pix_a (conv_a),
        .pix_b (conv_b),
        .y1    (y1_c),
        .y2    (y2_c),
        .u     (u_c),
        .v     (v_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EVEN;
            p1_reg        <= '0;
            pix_cnt_reg   <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            m_data_reg    <= '0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
            pair_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (s_fire && state_reg == ST_EVEN && !eff_last)
                p1_reg <= s_data;
            if (s_fire)
                pix_cnt_reg <= eff_last ? 12'd0 : pix_cnt_reg + 12'd1;
            // emit can only happen when the output slot is free or draining
            if (emit) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= {v_c, y2_c, u_c, y1_c};
                m_last_reg  <= eff_last;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
            if (m_valid_reg && m_ready)
                pair_cnt_reg <= pair_cnt_reg + 16'd1;
            if (set_short)
                err_short_reg <= 1'b1;
            else if (err_clr)
                err_short_reg <= 1'b0;
            if (set_long)
                err_long_reg <= 1'b1;
            else if (err_clr)
                err_long_reg <= 1'b0;
        end
    end

    assign m_valid   = m_valid_reg;
    assign m_data    = m_data_reg;
    assign m_last    = m_last_reg;
    assign err_short = err_short_reg;
    assign err_long  = err_long_reg;
    assign pair_cnt  = pair_cnt_reg;
endmodule
